// File: rtl/simon_stream_ctrl.sv
// Byte-serial command/data controller between UART FIFOs and an iterative SIMON engine.
// Handles key load, block encrypt/decrypt, result streaming, timeouts and error replies.
module simon_stream_ctrl #(
  parameter int BLOCK_BYTES    = 8,
  parameter int KEY_BYTES      = 12,
  parameter int TIMEOUT_CYCLES = 10_000_000
) (
  input  logic                     clk_100MHz,
  input  logic                     reset,
  input  logic [7:0]               rx_data,
  input  logic                     rx_empty,
  output logic                     rd_uart,
  input  logic                     tx_full,
  output logic                     wr_uart,
  output logic [7:0]               tx_data,
  output logic                     cph_start,
  output logic                     cph_mode,
  output logic [8*KEY_BYTES-1:0]   cph_key,
  output logic [8*BLOCK_BYTES-1:0] cph_text,
  input  logic                     cph_done,
  input  logic [8*BLOCK_BYTES-1:0] cph_result,
  output logic                     key_valid,
  output logic                     busy,
  output logic [7:0]               err_count
);

  localparam int MAX_BYTES = (KEY_BYTES > BLOCK_BYTES) ? KEY_BYTES : BLOCK_BYTES;
  localparam int SH_W      = 8 * MAX_BYTES;
  localparam int KEY_W     = 8 * KEY_BYTES;
  localparam int BLK_W     = 8 * BLOCK_BYTES;
  localparam int CNT_W     = $clog2(MAX_BYTES + 1);
  localparam int TO_W      = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [7:0] CMD_K     = 8'h4B;
  localparam logic [7:0] CMD_E     = 8'h45;
  localparam logic [7:0] CMD_D     = 8'h44;
  localparam logic [7:0] RPL_ACK   = 8'h06;
  localparam logic [7:0] RPL_NOKEY = 8'h21;
  localparam logic [7:0] RPL_UNK   = 8'h3F;
  localparam logic [7:0] RPL_TMO   = 8'h15;

  typedef enum logic [2:0] {
    S_IDLE, S_DISPATCH, S_LOAD_KEY, S_LOAD_TEXT, S_START, S_WAIT, S_SEND, S_REPLY
  } state_t;

  state_t            state_reg, state_next;
  logic [7:0]        cmd_reg, cmd_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [TO_W-1:0]   to_reg, to_next;
  logic [SH_W-1:0]   shift_reg, shift_next;
  logic [KEY_W-1:0]  key_reg, key_next;
  logic              kv_reg, kv_next;
  logic [BLK_W-1:0]  text_reg, text_next;
  logic              mode_reg, mode_next;
  logic [BLK_W-1:0]  txsh_reg, txsh_next;
  logic [7:0]        reply_reg, reply_next;
  logic [7:0]        err_reg, err_next;
  logic              err_inc;
  logic              last_byte;
  logic [SH_W-1:0]   shifted;

  assign shifted   = {shift_reg[SH_W-9:0], rx_data};
  assign cph_key   = key_reg;
  assign cph_text  = text_reg;
  assign cph_mode  = mode_reg;
  assign key_valid = kv_reg;
  assign err_count = err_reg;
  assign busy      = (state_reg != S_IDLE);

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      state_reg <= S_IDLE;
      cmd_reg   <= '0;
      cnt_reg   <= '0;
      to_reg    <= '0;
      shift_reg <= '0;
      key_reg   <= '0;
      kv_reg    <= 1'b0;
      text_reg  <= '0;
      mode_reg  <= 1'b0;
      txsh_reg  <= '0;
      reply_reg <= '0;
      err_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cmd_reg   <= cmd_next;
      cnt_reg   <= cnt_next;
      to_reg    <= to_next;
      shift_reg <= shift_next;
      key_reg   <= key_next;
      kv_reg    <= kv_next;
      text_reg  <= text_next;
      mode_reg  <= mode_next;
      txsh_reg  <= txsh_next;
      reply_reg <= reply_next;
      err_reg   <= err_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cmd_next   = cmd_reg;
    cnt_next   = cnt_reg;
    to_next    = to_reg;
    shift_next = shift_reg;
    key_next   = key_reg;
    kv_next    = kv_reg;
    text_next  = text_reg;
    mode_next  = mode_reg;
    txsh_next  = txsh_reg;
    reply_next = reply_reg;
    err_inc    = 1'b0;
    rd_uart    = 1'b0;
    wr_uart    = 1'b0;
    tx_data    = 8'h00;
    cph_start  = 1'b0;
    last_byte  = (state_reg == S_LOAD_KEY) ? (cnt_reg == CNT_W'(KEY_BYTES - 1))
                                           : (cnt_reg == CNT_W'(BLOCK_BYTES - 1));
    case (state_reg)
      S_IDLE: begin
        if (!rx_empty) begin
          rd_uart    = 1'b1;
          cmd_next   = rx_data;
          state_next = S_DISPATCH;
        end
      end
      S_DISPATCH: begin
        cnt_next = '0;
        to_next  = '0;
        if (cmd_reg == CMD_K) begin
          state_next = S_LOAD_KEY;
        end else if (cmd_reg == CMD_E || cmd_reg == CMD_D) begin
          if (kv_reg) begin
            mode_next  = (cmd_reg == CMD_D);
            state_next = S_LOAD_TEXT;
          end else begin
            reply_next = RPL_NOKEY;
            err_inc    = 1'b1;
            state_next = S_REPLY;
          end
        end else begin
          reply_next = RPL_UNK;
          err_inc    = 1'b1;
          state_next = S_REPLY;
        end
      end
      S_LOAD_KEY, S_LOAD_TEXT: begin
        // Timeout wins over a byte arriving the same cycle; that byte stays queued.
        if (to_reg == TO_W'(TIMEOUT_CYCLES)) begin
          shift_next = '0;
          reply_next = RPL_TMO;
          err_inc    = 1'b1;
          state_next = S_REPLY;
        end else if (!rx_empty) begin
          rd_uart    = 1'b1;
          shift_next = shifted;
          cnt_next   = cnt_reg + CNT_W'(1);
          to_next    = '0;
          if (last_byte) begin
            if (state_reg == S_LOAD_KEY) begin
              key_next   = shifted[KEY_W-1:0];
              kv_next    = 1'b1;
              reply_next = RPL_ACK;
              state_next = S_REPLY;
            end else begin
              text_next  = shifted[BLK_W-1:0];
              state_next = S_START;
            end
          end
        end else begin
          to_next = to_reg + TO_W'(1);
        end
      end
      S_START: begin
        cph_start  = 1'b1;
        state_next = S_WAIT;
      end
      S_WAIT: begin
        if (cph_done) begin
          txsh_next  = cph_result;
          cnt_next   = '0;
          state_next = S_SEND;
        end
      end
      S_SEND: begin
        tx_data = txsh_reg[BLK_W-1 -: 8];
        if (!tx_full) begin
          wr_uart   = 1'b1;
          txsh_next = txsh_reg << 8;
          cnt_next  = cnt_reg + CNT_W'(1);
          if (cnt_reg == CNT_W'(BLOCK_BYTES - 1)) state_next = S_IDLE;
        end
      end
      S_REPLY: begin
        tx_data = reply_reg;
        if (!tx_full) begin
          wr_uart    = 1'b1;
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
    err_next = (err_inc && err_reg != 8'hFF) ? err_reg + 8'd1 : err_reg;
  end

endmodule

// File: doc/simon_stream_ctrl.md
Name: simon_stream_ctrl

Overview:
- Sequential command/data controller that sits between the UART core's byte FIFOs and an iterative SIMON cipher engine.
- Replaces fixed-width parallel buffer capture and combinational encryption with a byte-serial command protocol:
  - load key once;
  - encrypt or decrypt any number of blocks;
  - stream each result back over TX.
- Adds per-message timeout, error replies and an error counter.

Parameters:
- BLOCK_BYTES, 8: cipher block size in bytes (64-bit block).
- KEY_BYTES, 12: key size in bytes (96-bit key).
- TIMEOUT_CYCLES, 10_000_000: idle cycles allowed between payload bytes before the partial message is aborted (100 ms at 100 MHz).

Ports:
- clk_100MHz  in  1  system clock
- reset  in  1  synchronous, active-high reset
- rx_data  in  8  head byte of RX FIFO (first-word-fall-through; valid when rx_empty=0)
- rx_empty  in  1  RX FIFO empty
- rd_uart  out  1  pop RX FIFO (1-cycle pulse per byte)
- tx_full  in  1  TX FIFO full
- wr_uart  out  1  push tx_data into TX FIFO
- tx_data  out  8  byte to transmit
- cph_start  out  1  1-cycle start pulse to cipher engine
- cph_mode  out  1  0 = encrypt, 1 = decrypt
- cph_key  out  8*KEY_BYTES  key, stable from cph_start until cph_done
- cph_text  out  8*BLOCK_BYTES  input block, stable from cph_start until cph_done
- cph_done  in  1  1-cycle pulse: cph_result valid
- cph_result  in  8*BLOCK_BYTES  cipher output
- key_valid  out  1  a complete key has been loaded
- busy  out  1  state != IDLE
- err_count  out  8  saturating error counter

Behaviour:
- Reset (synchronous, takes effect from any state, including mid-load, mid-WAIT and mid-SEND):
  - state = IDLE.
  - All outputs 0; key register and shift register 0; key_valid = 0; err_count = 0.
- RX pop rule:
  - rd_uart asserts only when rx_empty=0 and the state accepts a byte.
  - The byte consumed is rx_data in that same cycle.
  - At most one pop per cycle.
- TX push rule:
  - wr_uart asserts only when tx_full=0.
  - tx_data is valid in the same cycle.
  - While tx_full=1, hold the byte; no bytes are lost or duplicated.
- Byte order: first byte received lands in the MSB; results are sent MSB-first.
- Commands (first byte of a message): 0x4B 'K' load key; 0x45 'E' encrypt; 0x44 'D' decrypt.
- Reply codes:
  - 0x06 key loaded;
  - 0x21 'E'/'D' received without a valid key;
  - 0x3F unknown command;
  - 0x15 timeout.
- States:
  - IDLE: on rx_empty=0, pop the byte, latch it as cmd, go to DISPATCH.
  - DISPATCH:
    - 'K' → LOAD_KEY.
    - 'E'/'D' with key_valid=1 → LOAD_TEXT, with cph_mode = (cmd=='D').
    - 'E'/'D' with key_valid=0 → REPLY 0x21, err_count+1.
    - Any other byte → REPLY 0x3F, err_count+1.
    - Byte counter and timeout counter cleared on entry to LOAD_KEY and LOAD_TEXT.
  - LOAD_KEY: pop and shift bytes into the shift register.
    - After KEY_BYTES bytes, copy into the key register, set key_valid=1, go to REPLY 0x06.
  - LOAD_TEXT: pop and shift BLOCK_BYTES bytes, then copy into cph_text and go to START.
  - START: cph_start=1 for exactly one cycle, then go to WAIT.
  - WAIT: on cph_done, latch cph_result into the output shift register, then go to SEND. No timeout in WAIT.
  - SEND: push BLOCK_BYTES bytes, then return to IDLE.
  - REPLY: push one reply byte, then return to IDLE.
- Timeout (LOAD_KEY and LOAD_TEXT only):
  - The counter increments on each cycle with no pop and clears on each pop.
  - When it reaches TIMEOUT_CYCLES: discard the partial message, err_count+1, go to REPLY 0x15.
  - On a KEY timeout, the previous key and key_valid are unchanged, because the key is written only on completion.
- err_count saturates at 255.
- cph_done outside WAIT is ignored.
- A simultaneous rx byte and state exit is not popped; it stays in the FIFO for the next state.
- Counter widths:
  - byte counter: $clog2(max(KEY_BYTES,BLOCK_BYTES)+1);
  - timeout counter: $clog2(TIMEOUT_CYCLES+1).
- A key loaded once serves unlimited blocks until the next 'K' or reset.

Test Plan:
- Key load: 'K' then bytes 13 12 11 10 0b 0a 09 08 03 02 01 00 → cph_key=0x131211100b0a090803020100, key_valid=1, TX 0x06, exactly 13 rd_uart pulses.
- Encrypt: after key load, 'E' then 6f 72 20 67 6e 69 6c 63; bench cipher model returns 0x5ca2e27f111a8fc8 after 40 cycles → one cph_start pulse, cph_mode=0, cph_text=0x6f7220676e696c63, TX 5c a2 e2 7f 11 1a 8f c8 in order. Repeat with 'D' → cph_mode=1.
- Errors: 'E' after reset → TX 0x21, err_count=1, no cph_start. Then 0x58 → TX 0x3F, err_count=2.
- Timeout (TIMEOUT_CYCLES=100): 'E' plus 3 bytes, then 100 idle cycles → TX 0x15, err_count+1. A following full 'D' message is framed correctly. 'K' plus 5 bytes then timeout → old key and key_valid unchanged.
- Backpressure: tx_full=1 for 50 cycles mid-SEND → wr_uart stays 0. All 8 bytes delivered once, in order, after release.
- Reset mid-LOAD_KEY and mid-WAIT → next cycle busy=0, key_valid=0, err_count=0. A later cph_done is ignored with no TX.
